// File: rtl/div_issue_seq.sv
// Issue sequencer for a multi-cycle combinational divider: holds operands for LATENCY
// cycles, captures the result, and hands it to writeback. Optional div_zero output via DIV_ZERO_FLAG_EN.
module div_issue_seq #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_isDiv,
  input  logic        in_isMod,
  input  logic [3:0]  in_rd,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_isDiv,
  output logic        div_isMod,
  input  logic [31:0] div_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_rd,
  output logic        busy
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic        div_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        isdiv_q, isdiv_d;
  logic        ismod_q, ismod_d;
  logic [3:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  ord_q, ord_d;
`ifdef DIV_ZERO_FLAG_EN
  logic        zero_q, zero_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    isdiv_d = isdiv_q;
    ismod_d = ismod_q;
    rd_d    = rd_q;
    res_d   = res_q;
    ord_d   = ord_q;
`ifdef DIV_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          isdiv_d = in_isDiv;
          ismod_d = in_isMod;
          rd_d    = in_rd;
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Counter reaching zero marks the LATENCY-th edge after acceptance.
        if (cnt_q == '0) begin
          res_d   = div_result;
          ord_d   = rd_q;
`ifdef DIV_ZERO_FLAG_EN
          zero_d  = (b_q == '0);
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      isdiv_q <= 1'b0;
      ismod_q <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      ord_q   <= '0;
`ifdef DIV_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      isdiv_q <= isdiv_d;
      ismod_q <= ismod_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      ord_q   <= ord_d;
`ifdef DIV_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign div_isDiv  = isdiv_q;
  assign div_isMod  = ismod_q;
  assign out_result = res_q;
  assign out_rd     = ord_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero   = zero_q;
`endif

endmodule

// File: tb/tb_div_issue_seq.sv
// Self-checking bench for div_issue_seq: a LATENCY=4 instance for single-op scenarios and a
// LATENCY=1 instance for back-to-back issue, both fed by a behavioural divider stub.
module tb_div_issue_seq;

  localparam int unsigned L4 = 4;
  localparam int unsigned L1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_isDiv, in_isMod, div_isDiv, div_isMod;
  logic        out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, div_a, div_b, div_result, out_result;
  logic [3:0]  in_rd, out_rd;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero, div_zero1;
`endif

  logic        in_valid1, in_ready1, in_isDiv1, in_isMod1, div_isDiv1, div_isMod1;
  logic        out_valid1, out_ready1, busy1;
  logic [31:0] in_a1, in_b1, div_a1, div_b1, div_result1, out_result1;
  logic [3:0]  in_rd1, out_rd1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stand-in for the combinational divider the sequencer drives.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic d, input logic m);
    if (b == 32'd0) return 32'd0;
    if (d && !m) return a / b;
    if (m && !d) return a % b;
    return a ^ b;
  endfunction

  assign div_result  = ref_div(div_a, div_b, div_isDiv, div_isMod);
  assign div_result1 = ref_div(div_a1, div_b1, div_isDiv1, div_isMod1);

  div_issue_seq #(.LATENCY(L4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_isDiv(in_isDiv), .in_isMod(in_isMod), .in_rd(in_rd),
    .div_a(div_a), .div_b(div_b), .div_isDiv(div_isDiv), .div_isMod(div_isMod),
    .div_result(div_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .busy(busy)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero(div_zero)
`endif
  );

  div_issue_seq #(.LATENCY(L1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_isDiv(in_isDiv1), .in_isMod(in_isMod1), .in_rd(in_rd1),
    .div_a(div_a1), .div_b(div_b1), .div_isDiv(div_isDiv1), .div_isMod(div_isMod1),
    .div_result(div_result1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_result(out_result1), .out_rd(out_rd1), .busy(busy1)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero(div_zero1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++; $display("FAIL reset_flags got v/b/r=%b%b%b want 001", out_valid, busy, in_ready);
    end
    total++;
    if (out_result !== 32'd0 || out_rd !== 4'd0 || div_a !== 32'd0 || div_b !== 32'd0) begin
      bad++; $display("FAIL reset_regs got res=%h rd=%h a=%h b=%h want zeros", out_result, out_rd, div_a, div_b);
    end
    total++;
    if ({out_valid1, busy1, in_ready1} !== 3'b001) begin
      bad++; $display("FAIL reset_flags_l1 got v/b/r=%b%b%b want 001", out_valid1, busy1, in_ready1);
    end
  endtask

  // One operation through the LATENCY=4 instance, holding out_ready low for 'stall' DONE cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic d, input logic m,
                       input logic [3:0] rd, input int stall, input string tag);
    int n;
    int acc;
    logic [31:0] exp;
    exp = ref_div(a, b, d, m);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    total++;
    if (!in_ready) begin
      bad++; $display("FAIL %s ready_timeout got in_ready=0 want 1", tag);
      return;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_isDiv = d; in_isMod = m; in_rd = rd;
    out_ready = 1'b0;
    tick();
    acc = cyc;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_rd = 4'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      total++;
      if (div_a !== a || div_b !== b || div_isDiv !== d || div_isMod !== m || busy !== 1'b1) begin
        bad++; $display("FAIL %s hold got a=%h b=%h d=%b m=%b busy=%b want a=%h b=%h d=%b m=%b busy=1",
                        tag, div_a, div_b, div_isDiv, div_isMod, busy, a, b, d, m);
      end
      out_ready = 1'($urandom);
      tick(); n++;
    end
    out_ready = 1'b0;
    total++;
    if (!out_valid || cyc - acc != int'(L4)) begin
      bad++; $display("FAIL %s latency got valid=%b after %0d want valid=1 after %0d", tag, out_valid, cyc - acc, L4);
    end
    total++;
    if (out_result !== exp || out_rd !== rd) begin
      bad++; $display("FAIL %s result got %h rd=%h want %h rd=%h", tag, out_result, out_rd, exp, rd);
    end
`ifdef DIV_ZERO_FLAG_EN
    total++;
    if (div_zero !== (b == 32'd0)) begin
      bad++; $display("FAIL %s div_zero got %b want %b", tag, div_zero, (b == 32'd0));
    end
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_result !== exp || out_rd !== rd || in_ready !== 1'b0 || div_a !== a) begin
        bad++; $display("FAIL %s stall%0d got v=%b res=%h rd=%h rdy=%b a=%h want v=1 res=%h rd=%h rdy=0 a=%h",
                        tag, i, out_valid, out_result, out_rd, in_ready, div_a, exp, rd, a);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_result !== exp || out_rd !== rd) begin
      bad++; $display("FAIL %s release got v=%b rdy=%b busy=%b res=%h rd=%h want v=0 rdy=1 busy=0 res=%h rd=%h",
                      tag, out_valid, in_ready, busy, out_result, out_rd, exp, rd);
    end
  endtask

  task automatic test_fixed();
    do_op(32'd100, 32'd7, 1'b1, 1'b0, 4'd5, 0, "div100_7");
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 4'd9, 1, "mod100_7");
    do_op(32'd5, 32'd0, 1'b1, 1'b0, 4'd3, 0, "div5_0");
  endtask

  task automatic test_stall();
    do_op(32'd100, 32'd7, 1'b1, 1'b0, 4'd12, 3, "stall3");
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      do_op(a, b, 1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_wait();
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd7; in_isDiv = 1'b1; in_isMod = 1'b0; in_rd = 4'd6;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 4'd0 || div_a !== 32'd0) begin
      bad++; $display("FAIL rst_wait got rdy=%b v=%b res=%h rd=%h a=%h want rdy=1 v=0 zeros",
                      in_ready, out_valid, out_result, out_rd, div_a);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rst_wait_quiet cyc%0d got v=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    int          acc;
  } exp_t;

  task automatic test_back_to_back();
    exp_t q[$];
    int last_acc = -1;
    int naccs = 0;
    logic acc_now;
    in_a1 = $urandom; in_b1 = 32'($urandom_range(0, 20)); in_isDiv1 = 1'($urandom);
    in_isMod1 = 1'($urandom); in_rd1 = 4'($urandom);
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc_now = in_valid1 && in_ready1;
      if (acc_now) q.push_back('{ref_div(in_a1, in_b1, in_isDiv1, in_isMod1), in_rd1, cyc + 1});
      tick();
      if (acc_now) begin
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != int'(L1) + 2) begin
            bad++; $display("FAIL b2b_period got %0d want %0d", cyc - last_acc, L1 + 2);
          end
        end
        last_acc = cyc; naccs++;
        in_a1 = $urandom; in_b1 = 32'($urandom_range(0, 20)); in_isDiv1 = 1'($urandom);
        in_isMod1 = 1'($urandom); in_rd1 = 4'($urandom);
      end
      if (out_valid1) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_spurious got out_valid=1 want 0");
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_result1 !== e.res || out_rd1 !== e.rd || cyc - e.acc != int'(L1)) begin
            bad++; $display("FAIL b2b_result got %h rd=%h lat=%0d want %h rd=%h lat=%0d",
                            out_result1, out_rd1, cyc - e.acc, e.res, e.rd, L1);
          end
        end
      end
    end
    in_valid1 = 1'b0;
    total++;
    if (naccs < 12) begin
      bad++; $display("FAIL b2b_count got %0d want >=12", naccs);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_isDiv = 1'b0; in_isMod = 1'b0; in_rd = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_isDiv1 = 1'b0; in_isMod1 = 1'b0; in_rd1 = '0; out_ready1 = 1'b0;
    tick(); tick();
    test_reset();
    test_fixed();
    test_stall();
    test_random();
    test_reset_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
